// File: rtl/lm75_mon_pkg.sv
`default_nettype none
// ============================================================================
// Package     : lm75_mon_pkg
// Description : Shared definitions for the LM75 temperature monitor.
//               - FSM state encoding (IDLE / RUN / FAULT).
//               - Temperature width constant.
//               - Conversion of the raw LM75 register to signed 1/8 degC.
// Revision    : 1.0 - initial release
// ============================================================================
package lm75_mon_pkg;

    localparam int TEMP_W         = 16;
    localparam int LM75_LSB_SHIFT = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_t;

    // The 11-bit reading sits in [15:5]. An arithmetic shift sign-extends it
    // and leaves a signed value in 0.125 degC units.
    function automatic logic [TEMP_W-1:0] lm75_to_eighths(input logic [TEMP_W-1:0] raw);
        return TEMP_W'($signed(raw) >>> LM75_LSB_SHIFT);
    endfunction

endpackage : lm75_mon_pkg
`default_nettype wire

// File: rtl/moving_avg_pow2.sv
`default_nettype none
// ============================================================================
// Module      : moving_avg_pow2
// Description : Moving average over a 2^AVG_LOG2-deep window of signed samples.
//               Uses a ring buffer and a running sum, so each push costs one
//               subtract and one add.
// Ports       : clk       - clock
//               rst_n     - asynchronous reset, active low
//               i_preload - fill every ring entry with i_value and set the sum
//               i_push    - replace the oldest entry with i_value
//               i_value   - signed sample, 1/8 degC
//               o_avg     - floor(sum / 2^AVG_LOG2), signed
// Revision    : 1.0 - initial release
// ============================================================================
module moving_avg_pow2
    import lm75_mon_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_preload,
    input  logic              i_push,
    input  logic [TEMP_W-1:0] i_value,
    output logic [TEMP_W-1:0] o_avg
);

    localparam int DEPTH = 1 << AVG_LOG2;
    // A sum of DEPTH values of TEMP_W bits needs AVG_LOG2 extra bits, so it
    // cannot overflow.
    localparam int SUM_W = TEMP_W + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] C_WP_ONE = AVG_LOG2'(1);

    logic [TEMP_W-1:0]       r_ring [DEPTH];
    logic [AVG_LOG2-1:0]     r_wp;
    logic signed [SUM_W-1:0] r_sum;

    logic signed [SUM_W-1:0] w_val_ext;
    logic signed [SUM_W-1:0] w_old_ext;

    assign w_val_ext = {{AVG_LOG2{i_value[TEMP_W-1]}}, i_value};
    assign w_old_ext = {{AVG_LOG2{r_ring[r_wp][TEMP_W-1]}}, r_ring[r_wp]};

    // The arithmetic shift rounds toward minus infinity.
    assign o_avg = TEMP_W'(r_sum >>> AVG_LOG2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_wp  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ring[i] <= '0;
            end
        end else if (i_preload) begin
            r_sum <= w_val_ext <<< AVG_LOG2;
            r_wp  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ring[i] <= i_value;
            end
        end else if (i_push) begin
            r_sum        <= r_sum - w_old_ext + w_val_ext;
            r_ring[r_wp] <= i_value;
            r_wp         <= r_wp + C_WP_ONE;
        end
    end

endmodule : moving_avg_pow2
`default_nettype wire

// File: rtl/lm75_temp_monitor.sv
`default_nettype none
// ============================================================================
// Module      : lm75_temp_monitor
// Description : Samples the LM75 reading at a fixed rate and converts it to
//               signed 1/8 degC. It smooths the readings, raises a hysteretic
//               over-temperature alarm and flags a sensor fault when valid
//               data stops arriving.
// Config      : LM75_MINMAX_EN - adds min/max tracking of the averaged value
//               (ports minmax_clr, temp_min, temp_max).
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               lm75_temp        - raw LM75 register ([15:5] signed temp)
//               lm75_valid       - level: last bus transaction error-free
//               temp_avg         - averaged temperature, signed 1/8 degC
//               temp_avg_valid   - temp_avg holds a real average (RUN)
//               over_temp        - hysteretic alarm, forced high in FAULT
//               sensor_fault     - FAULT_COUNT consecutive invalid ticks
// Latency     : a sample is taken on tick cycle T. temp_avg and
//               temp_avg_valid change at T+2 and over_temp at T+3.
// Revision    : 1.0 - initial release
// ============================================================================
module lm75_temp_monitor
    import lm75_mon_pkg::*;
#(
    parameter int SAMPLE_DIV  = 2700000,
    parameter int AVG_LOG2    = 3,
    parameter int TEMP_HIGH   = 640,
    parameter int TEMP_HYST   = 40,
    parameter int FAULT_COUNT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TEMP_W-1:0] lm75_temp,
    input  logic              lm75_valid,
    output logic [TEMP_W-1:0] temp_avg,
    output logic              temp_avg_valid,
    output logic              over_temp,
    output logic              sensor_fault
`ifdef LM75_MINMAX_EN
    ,
    input  logic              minmax_clr,
    output logic [TEMP_W-1:0] temp_min,
    output logic [TEMP_W-1:0] temp_max
`endif
);

    localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int MISS_W = $clog2(FAULT_COUNT + 1);

    localparam logic [CNT_W-1:0]  C_CNT_LAST   = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE    = CNT_W'(1);
    localparam logic [MISS_W-1:0] C_MISS_LIMIT = MISS_W'(FAULT_COUNT);
    localparam logic [MISS_W-1:0] C_MISS_ONE   = MISS_W'(1);
    // Widen to 17 bits so the threshold arithmetic cannot wrap.
    localparam logic signed [TEMP_W:0] C_SET = (TEMP_W+1)'(TEMP_HIGH);
    localparam logic signed [TEMP_W:0] C_CLR = (TEMP_W+1)'(TEMP_HIGH - TEMP_HYST);

    // ------------------------------------------------------------------
    // Sample tick and stage-1 capture
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  r_cnt;
    logic              w_tick;
    logic              r_tick1;
    logic              r_valid1;
    logic [TEMP_W-1:0] r_raw1;

    assign w_tick = (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_tick1  <= 1'b0;
            r_valid1 <= 1'b0;
            r_raw1   <= '0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + C_CNT_ONE;
            r_tick1 <= w_tick;
            // Input changes between ticks are ignored.
            if (w_tick) begin
                r_valid1 <= lm75_valid;
                r_raw1   <= lm75_temp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and miss counter
    // ------------------------------------------------------------------
    mon_state_t        r_state;
    mon_state_t        w_state_nxt;
    logic [MISS_W-1:0] r_miss;
    logic [MISS_W-1:0] w_miss_nxt;
    logic              w_preload;
    logic              w_push;
    logic              r_avg_upd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_miss    <= '0;
            r_avg_upd <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_miss    <= w_miss_nxt;
            r_avg_upd <= w_preload | w_push;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_miss_nxt  = r_miss;
        w_preload   = 1'b0;
        w_push      = 1'b0;
        if (r_tick1) begin
            if (r_valid1) begin
                w_miss_nxt = '0;
                if (r_state == ST_RUN) begin
                    w_push = 1'b1;
                end else begin
                    // From IDLE or FAULT the window restarts full of the
                    // new sample, so the first average is meaningful.
                    w_preload   = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end else begin
                if (r_miss != C_MISS_LIMIT) begin
                    w_miss_nxt = r_miss + C_MISS_ONE;
                end
                if (w_miss_nxt == C_MISS_LIMIT) begin
                    w_state_nxt = ST_FAULT;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Averaging
    // ------------------------------------------------------------------
    moving_avg_pow2 #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_preload (w_preload),
        .i_push    (w_push),
        .i_value   (lm75_to_eighths(r_raw1)),
        .o_avg     (temp_avg)
    );

    assign temp_avg_valid = (r_state == ST_RUN);
    assign sensor_fault   = (r_state == ST_FAULT);

    // ------------------------------------------------------------------
    // Over-temperature alarm
    // ------------------------------------------------------------------
    logic                     r_over;
    logic signed [TEMP_W:0]   w_avg_ext;

    assign w_avg_ext = {temp_avg[TEMP_W-1], temp_avg};
    assign over_temp = r_over;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_over <= 1'b0;
        end else if (w_state_nxt == ST_FAULT) begin
            // Fail-safe: with no trustworthy reading, assume hot.
            r_over <= 1'b1;
        end else if (r_avg_upd) begin
            if (w_avg_ext >= C_SET) begin
                r_over <= 1'b1;
            end else if (w_avg_ext < C_CLR) begin
                r_over <= 1'b0;
            end
        end
    end

`ifdef LM75_MINMAX_EN
    // ------------------------------------------------------------------
    // Min / max of the averaged temperature
    // ------------------------------------------------------------------
    logic r_mm_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mm_first <= 1'b1;
            temp_min   <= '0;
            temp_max   <= '0;
        end else if (r_avg_upd) begin
            // A coinciding clear loads the updated value as well.
            r_mm_first <= 1'b0;
            if (r_mm_first || minmax_clr) begin
                temp_min <= temp_avg;
                temp_max <= temp_avg;
            end else begin
                if ($signed(temp_avg) < $signed(temp_min)) temp_min <= temp_avg;
                if ($signed(temp_avg) > $signed(temp_max)) temp_max <= temp_avg;
            end
        end else if (minmax_clr) begin
            r_mm_first <= 1'b1;
            temp_min   <= temp_avg;
            temp_max   <= temp_avg;
        end else if (w_state_nxt == ST_FAULT) begin
            r_mm_first <= 1'b1;
        end
    end
`endif

endmodule : lm75_temp_monitor
`default_nettype wire

// File: tb/tb_lm75_temp_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_lm75_temp_monitor
// Description : Directed, self-checking bench for lm75_temp_monitor with
//               SAMPLE_DIV=4, AVG_LOG2=1 (window of 2), TEMP_HIGH=640,
//               TEMP_HYST=40, FAULT_COUNT=4. Capture edges fall every
//               4 cycles. Each tick() call leaves time just after the second
//               edge following a capture, when both the average and the
//               alarm have settled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lm75_temp_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] lm75_temp = 16'h0000;
    logic        lm75_valid = 1'b0;
    logic [15:0] temp_avg;
    logic        temp_avg_valid;
    logic        over_temp;
    logic        sensor_fault;
`ifdef LM75_MINMAX_EN
    logic        minmax_clr = 1'b0;
    logic [15:0] temp_min;
    logic [15:0] temp_max;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lm75_temp_monitor #(
        .SAMPLE_DIV  (4),
        .AVG_LOG2    (1),
        .TEMP_HIGH   (640),
        .TEMP_HYST   (40),
        .FAULT_COUNT (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lm75_temp      (lm75_temp),
        .lm75_valid     (lm75_valid),
        .temp_avg       (temp_avg),
        .temp_avg_valid (temp_avg_valid),
        .over_temp      (over_temp),
        .sensor_fault   (sensor_fault)
`ifdef LM75_MINMAX_EN
        ,
        .minmax_clr     (minmax_clr),
        .temp_min       (temp_min),
        .temp_max       (temp_max)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d (0x%h) expected=%0d (0x%h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    // One sample period. Inputs change two edges before the capture edge.
    task automatic tick(input logic [15:0] raw, input logic v);
        lm75_temp  = raw;
        lm75_valid = v;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // After reset is released, move to the phase that tick() expects.
    task automatic align();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_avg",   temp_avg,       16'd0);
        check("rst_valid", temp_avg_valid, 16'd0);
        check("rst_over",  over_temp,      16'd0);
        check("rst_fault", sensor_fault,   16'd0);
        rst_n = 1'b1;
        align();

        // ---------------- 1: 0x1900 -> 200, latency T+2 ----------------
        lm75_temp  = 16'h1900;
        lm75_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t1_avg_T+1",   temp_avg,       16'd0);
        check("t1_valid_T+1", temp_avg_valid, 16'd0);
        @(posedge clk);
        #1;
        check("t1_avg_T+2",   temp_avg,       16'd200);
        check("t1_valid_T+2", temp_avg_valid, 16'd1);
        @(posedge clk);
        #1;
        check("t1_over",  over_temp,    16'd0);
        check("t1_fault", sensor_fault, 16'd0);
`ifdef LM75_MINMAX_EN
        check("t1_min", temp_min, 16'd200);
        check("t1_max", temp_max, 16'd200);
`endif

        // ---------------- 2: negative values, floor rounding ----------------
        tick(16'hE700, 1'b1);                       // (200 + -200)/2
        check("t2_avg_mix", temp_avg, 16'd0);
        tick(16'hE700, 1'b1);
        check("t2_avg_neg", temp_avg, 16'hFF38);    // -200
`ifdef LM75_MINMAX_EN
        check("t2_min", temp_min, 16'hFF38);
        check("t2_max", temp_max, 16'd200);
        minmax_clr = 1'b1;
`endif
        // One extra period that holds the same input (window stays -200).
        @(posedge clk);
        #1;
`ifdef LM75_MINMAX_EN
        minmax_clr = 1'b0;
        check("t2_clr_min", temp_min, 16'hFF38);
        check("t2_clr_max", temp_max, 16'hFF38);
`endif
        repeat (3) @(posedge clk);
        #1;
        tick(16'h0000, 1'b1);
        tick(16'hFFE0, 1'b1);                       // (0 + -1)/2 -> -1
        check("t2_floor_a", temp_avg, 16'hFFFF);
        tick(16'h0000, 1'b1);
        check("t2_floor_b", temp_avg, 16'hFFFF);

        // ---------------- 3: alarm hysteresis ----------------
        tick(16'h1900, 1'b1);                       // (-1 + 200)/2 -> 99? window is {0,200}
        check("t3_avg_100", temp_avg, 16'd100);
        tick(16'h1900, 1'b1);
        check("t3_avg_200", temp_avg, 16'd200);
        tick(16'h5000, 1'b1);
        check("t3_avg_420", temp_avg, 16'd420);
        check("t3_over_420", over_temp, 16'd0);
        lm75_temp = 16'h5000;
        repeat (3) @(posedge clk);
        #1;
        check("t3_avg_640",    temp_avg,  16'd640);
        check("t3_over_T+2",   over_temp, 16'd0);
        @(posedge clk);
        #1;
        check("t3_over_set",   over_temp, 16'd1);
        tick(16'h4B00, 1'b1);
        check("t3_avg_620",    temp_avg,  16'd620);
        check("t3_over_620",   over_temp, 16'd1);
        tick(16'h4B00, 1'b1);
        check("t3_avg_600",    temp_avg,  16'd600);
        check("t3_over_600",   over_temp, 16'd1);
        tick(16'h4AE0, 1'b1);
        check("t3_avg_599",    temp_avg,  16'd599);
        check("t3_over_clear", over_temp, 16'd0);

        // ---------------- 4: sensor fault ----------------
        tick(16'h1234, 1'b0);
        tick(16'h1234, 1'b0);
        tick(16'h1234, 1'b0);
        check("t4_nofault",  sensor_fault,   16'd0);
        check("t4_valid3",   temp_avg_valid, 16'd1);
        check("t4_avg3",     temp_avg,       16'd599);
        check("t4_over3",    over_temp,      16'd0);
        tick(16'h1234, 1'b0);
        check("t4_fault",    sensor_fault,   16'd1);
        check("t4_over_fs",  over_temp,      16'd1);
        check("t4_valid_f",  temp_avg_valid, 16'd0);
        check("t4_avg_hold", temp_avg,       16'd599);
        tick(16'h1900, 1'b1);
        check("t4_rec_avg",   temp_avg,       16'd200);
        check("t4_rec_valid", temp_avg_valid, 16'd1);
        check("t4_rec_fault", sensor_fault,   16'd0);
        check("t4_rec_over",  over_temp,      16'd0);

        // ---------------- 5: asynchronous reset mid-operation ----------------
        tick(16'h5000, 1'b1);
        check("t5_avg_420", temp_avg, 16'd420);
        tick(16'h5000, 1'b1);
        check("t5_over_pre", over_temp, 16'd1);
        rst_n = 1'b0;
        #1;                                         // no clock edge in between
        check("t5_rst_avg",   temp_avg,       16'd0);
        check("t5_rst_valid", temp_avg_valid, 16'd0);
        check("t5_rst_over",  over_temp,      16'd0);
        check("t5_rst_fault", sensor_fault,   16'd0);
        #2;
        rst_n = 1'b1;
        align();
        tick(16'hE700, 1'b1);
        check("t5_preload_avg", temp_avg,       16'hFF38);
        check("t5_preload_val", temp_avg_valid, 16'd1);
        check("t5_preload_ovr", over_temp,      16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lm75_temp_monitor
`default_nettype wire
